// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the display buffer scheduler slice.
//   - default geometry (segments, rows, columns, bits per colour channel)
//   - address-width helper constants ROW_W, COL_W, ADDR_W and pixel width PIXEL_W
//   - scheduler FSM state encoding (S_CLEAR only with DISPLAY_BUFFER_SCHEDULER_CLEAR_EN)
package display_pkg;

  localparam int unsigned DEF_SEGMENTS   = 1;
  localparam int unsigned DEF_ROWS       = 8;
  localparam int unsigned DEF_COLUMNS    = 32;
  localparam int unsigned DEF_CYCLEWIDTH = 8;

  localparam int unsigned ROW_W   = $clog2(DEF_ROWS);
  localparam int unsigned COL_W   = $clog2(DEF_COLUMNS);
  localparam int unsigned ADDR_W  = 1 + ROW_W + COL_W;
  localparam int unsigned PIXEL_W = DEF_CYCLEWIDTH * 3 * DEF_SEGMENTS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SWAP_WAIT = 2'd1,
    S_SWAP      = 2'd2
`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
    ,S_CLEAR    = 2'd3
`endif
  } state_t;

  // Pixel word: one value per colour channel (RGB) per segment.
  function automatic int unsigned pixel_width(input int unsigned cyclewidth,
                                              input int unsigned segments);
    return cyclewidth * 3 * segments;
  endfunction

endpackage

// File: rtl/display_clear_counter.sv
// display_clear_counter: row-major sweep counter over one frame bank.
// Ports:
//   clk, rst (async, active-low)
//   start  - restart the sweep at (0,0)
//   step   - advance to the next column (wrapping into the next row)
//   row, column - current sweep position
//   done   - current position is the last one (rows-1, columns-1)
module display_clear_counter
  import display_pkg::*;
#(
  parameter int unsigned rows    = DEF_ROWS,
  parameter int unsigned columns = DEF_COLUMNS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       step,
  output logic [$clog2(rows)-1:0]    row,
  output logic [$clog2(columns)-1:0] column,
  output logic                       done
);

  localparam int unsigned RW = $clog2(rows);
  localparam int unsigned CW = $clog2(columns);
  localparam logic [RW-1:0] ROW_LAST = RW'(rows - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(columns - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row    <= '0;
      column <= '0;
    end else if (start) begin
      row    <= '0;
      column <= '0;
    end else if (step) begin
      if (column == COL_LAST) begin
        column <= '0;
        row    <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        column <= column + 1'b1;
      end
    end
  end

  assign done = (row == ROW_LAST) && (column == COL_LAST);

endmodule

// File: rtl/display_buffer_scheduler.sv
// display_buffer_scheduler: double-buffered frame memory scheduler.
// The driver reads the front bank; the writer (and the optional clear engine)
// fill the back bank; banks flip only at a driver frame_complete.
// Optional feature macro: DISPLAY_BUFFER_SCHEDULER_CLEAR_EN (adds clear_req
// and the S_CLEAR back-bank zero sweep).
// Ports:
//   clk, rst (async, active-low)
//   disp_row, disp_column, frame_complete  - from display_driver
//   rd_addr                                 - {front, disp_row, disp_column}, combinational
//   wr_req, wr_row, wr_column, wr_pixel, wr_ready - pixel writer handshake
//   swap_req, swap_pending, swap_done, front      - bank swap control/status
//   clear_req                                     - start back-bank clear (feature only)
//   mem_we, mem_waddr, mem_wdata                  - registered frame memory write port
//   frame_count                                   - frames displayed, wraps at 256
module display_buffer_scheduler
  import display_pkg::*;
#(
  parameter int unsigned segments   = DEF_SEGMENTS,
  parameter int unsigned rows       = DEF_ROWS,
  parameter int unsigned columns    = DEF_COLUMNS,
  parameter int unsigned cyclewidth = DEF_CYCLEWIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [$clog2(rows)-1:0]                       disp_row,
  input  logic [$clog2(columns)-1:0]                    disp_column,
  input  logic                                          frame_complete,
  output logic [$clog2(rows)+$clog2(columns):0]         rd_addr,
  input  logic                                          wr_req,
  input  logic [$clog2(rows)-1:0]                       wr_row,
  input  logic [$clog2(columns)-1:0]                    wr_column,
  input  logic [pixel_width(cyclewidth, segments)-1:0]  wr_pixel,
  output logic                                          wr_ready,
  input  logic                                          swap_req,
  output logic                                          swap_pending,
  output logic                                          swap_done,
  output logic                                          front,
`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
  input  logic                                          clear_req,
`endif
  output logic                                          mem_we,
  output logic [$clog2(rows)+$clog2(columns):0]         mem_waddr,
  output logic [pixel_width(cyclewidth, segments)-1:0]  mem_wdata,
  output logic [7:0]                                    frame_count
);

  localparam int unsigned RW = $clog2(rows);
  localparam int unsigned CW = $clog2(columns);
  localparam logic [RW:0] ROW_LIM = (RW + 1)'(rows);
  localparam logic [CW:0] COL_LIM = (CW + 1)'(columns);

  state_t state, next_state;
  logic   set_pending;
  logic   do_flip;
  logic   wr_accept;
  logic   wr_in_range;

`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
  logic          clear_start;
  logic          clear_step;
  logic [RW-1:0] clear_row;
  logic [CW-1:0] clear_column;
  logic          clear_done;

  display_clear_counter #(
    .rows    (rows),
    .columns (columns)
  ) u_clear_counter (
    .clk    (clk),
    .rst    (rst),
    .start  (clear_start),
    .step   (clear_step),
    .row    (clear_row),
    .column (clear_column),
    .done   (clear_done)
  );
`endif

  assign rd_addr     = {front, disp_row, disp_column};
  assign wr_ready    = (state == S_IDLE) && !swap_pending;
  assign wr_accept   = wr_req && wr_ready;
  assign wr_in_range = ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_column} < COL_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    set_pending = 1'b0;
    do_flip     = 1'b0;
`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
    clear_start = 1'b0;
    clear_step  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
        // Clear wins over a simultaneous swap_req; the swap is still latched
        // and serviced once the sweep finishes.
        if (clear_req && !swap_pending) begin
          next_state  = S_CLEAR;
          clear_start = 1'b1;
          set_pending = swap_req;
        end else
`endif
        if (swap_req && !swap_pending) begin
          set_pending = 1'b1;
          next_state  = S_SWAP_WAIT;
        end
      end
      S_SWAP_WAIT: begin
        if (frame_complete) next_state = S_SWAP;
      end
      S_SWAP: begin
        do_flip    = 1'b1;
        next_state = S_IDLE;
      end
`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
      S_CLEAR: begin
        clear_step  = 1'b1;
        set_pending = swap_req && !swap_pending;
        if (clear_done)
          next_state = (swap_pending || set_pending) ? S_SWAP_WAIT : S_IDLE;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= do_flip;
      if (do_flip) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if (set_pending) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Writes always target the back bank (~front); front cannot change while a
  // write is in flight because writes stall whenever a swap is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else if (wr_accept) begin
      mem_we    <= wr_in_range;
      mem_waddr <= {~front, wr_row, wr_column};
      mem_wdata <= wr_pixel;
`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
    end else if (clear_step) begin
      mem_we    <= 1'b1;
      mem_waddr <= {~front, clear_row, clear_column};
      mem_wdata <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                frame_count <= '0;
    else if (frame_complete) frame_count <= frame_count + 8'd1;
  end

endmodule

// File: tb/tb_display_buffer_scheduler.sv
// Directed self-checking bench for display_buffer_scheduler (default geometry),
// plus a 6x24 instance to exercise out-of-range write rejection.
module tb_display_buffer_scheduler;
  import display_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default-geometry DUT signals
  logic [ROW_W-1:0]   disp_row = '0;
  logic [COL_W-1:0]   disp_column = '0;
  logic               frame_complete = 1'b0;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wr_req = 1'b0;
  logic [ROW_W-1:0]   wr_row = '0;
  logic [COL_W-1:0]   wr_column = '0;
  logic [PIXEL_W-1:0] wr_pixel = '0;
  logic               wr_ready;
  logic               swap_req = 1'b0;
  logic               swap_pending, swap_done, front;
  logic               clear_req = 1'b0;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [PIXEL_W-1:0] mem_wdata;
  logic [7:0]         frame_count;

  // 6 rows x 24 columns DUT signals
  logic         wr2_req = 1'b0;
  logic [2:0]   wr2_row = '0;
  logic [4:0]   wr2_column = '0;
  logic [23:0]  wr2_pixel = '0;
  logic [8:0]   rd2_addr, mem2_waddr;
  logic         wr2_ready, swap2_pending, swap2_done, front2, mem2_we;
  logic [23:0]  mem2_wdata;
  logic [7:0]   frame2_count;

  int n_assert = 0;
  int n_fail   = 0;

  display_buffer_scheduler #(
    .segments(1), .rows(8), .columns(32), .cyclewidth(8)
  ) dut (
    .clk(clk), .rst(rst), .disp_row(disp_row), .disp_column(disp_column),
    .frame_complete(frame_complete), .rd_addr(rd_addr), .wr_req(wr_req),
    .wr_row(wr_row), .wr_column(wr_column), .wr_pixel(wr_pixel),
    .wr_ready(wr_ready), .swap_req(swap_req), .swap_pending(swap_pending),
    .swap_done(swap_done), .front(front),
`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
    .clear_req(clear_req),
`endif
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .frame_count(frame_count)
  );

  display_buffer_scheduler #(
    .segments(1), .rows(6), .columns(24), .cyclewidth(8)
  ) dut2 (
    .clk(clk), .rst(rst), .disp_row(3'd0), .disp_column(5'd0),
    .frame_complete(1'b0), .rd_addr(rd2_addr), .wr_req(wr2_req),
    .wr_row(wr2_row), .wr_column(wr2_column), .wr_pixel(wr2_pixel),
    .wr_ready(wr2_ready), .swap_req(1'b0), .swap_pending(swap2_pending),
    .swap_done(swap2_done), .front(front2),
`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
    .clear_req(1'b0),
`endif
    .mem_we(mem2_we), .mem_waddr(mem2_waddr), .mem_wdata(mem2_wdata),
    .frame_count(frame2_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;

    // Reset values while rst is held low
    repeat (3) @(posedge clk);
    #1;
    chk("rst_front", front, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_done", swap_done, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_fcount", frame_count, 0);
    rst = 1'b1;
    disp_row = 3'd3; disp_column = 5'd5;
    #1;
    chk("rd_addr_f0", rd_addr, 9'h065);
    chk("ready_idle", wr_ready, 1);

    // Out-of-range writes on 6x24 instance are accepted but not written
    wr2_req = 1'b1; wr2_row = 3'd1; wr2_column = 5'd24; wr2_pixel = 24'h111111;
    #1;
    chk("oor_col_ready", wr2_ready, 1);
    tick();
    chk("oor_col_we", mem2_we, 0);
    wr2_row = 3'd6; wr2_column = 5'd0;
    tick();
    chk("oor_row_we", mem2_we, 0);
    wr2_row = 3'd5; wr2_column = 5'd23; wr2_pixel = 24'h222222;
    tick();
    wr2_req = 1'b0;
    chk("edge_we", mem2_we, 1);
    chk("edge_waddr", mem2_waddr, 9'h1B7);
    tick();
    chk("edge_we_drop", mem2_we, 0);

    // Basic write: back bank is 1 while front is 0
    wr_req = 1'b1; wr_row = 3'd2; wr_column = 5'd7; wr_pixel = 24'hABCDEF;
    #1;
    chk("wr_ready", wr_ready, 1);
    tick();
    wr_req = 1'b0;
    chk("wr_we", mem_we, 1);
    chk("wr_waddr", mem_waddr, 9'h147);
    chk("wr_wdata", mem_wdata, 24'hABCDEF);
    tick();
    chk("wr_we_drop", mem_we, 0);

    // Swap held off for 100 cycles; writes stall meanwhile
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_req = 1'b1; wr_row = 3'd0; wr_column = 5'd0;
    #1;
    chk("sw_pending", swap_pending, 1);
    chk("sw_ready_low", wr_ready, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (swap_pending !== 1'b1 || wr_ready !== 1'b0 || mem_we !== 1'b0 || front !== 1'b0) bad++;
    end
    chk("sw_wait_100", bad, 0);
    wr_req = 1'b0;
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    chk("sw_not_yet", front, 0);
    chk("sw_done_not_yet", swap_done, 0);
    tick();
    chk("sw_front", front, 1);
    chk("sw_done", swap_done, 1);
    chk("sw_pending_clr", swap_pending, 0);
    chk("sw_ready_back", wr_ready, 1);
    tick();
    chk("sw_done_pulse", swap_done, 0);
    chk("fcount_1", frame_count, 1);

    // swap_req with frame_complete in the same cycle: wait for next frame end
    swap_req = 1'b1; frame_complete = 1'b1;
    tick();
    swap_req = 1'b0; frame_complete = 1'b0;
    repeat (5) tick();
    chk("same_front_held", front, 1);
    chk("same_pending", swap_pending, 1);
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    tick();
    chk("same_front", front, 0);
    chk("same_done", swap_done, 1);
    chk("fcount_3", frame_count, 3);

    // Write and swap_req together: write goes through, then swap pends
    wr_req = 1'b1; wr_row = 3'd5; wr_column = 5'd31; wr_pixel = 24'h123456;
    swap_req = 1'b1;
    #1;
    chk("ws_ready", wr_ready, 1);
    tick();
    wr_req = 1'b0; swap_req = 1'b0;
    chk("ws_we", mem_we, 1);
    chk("ws_waddr", mem_waddr, 9'h1BF);
    chk("ws_wdata", mem_wdata, 24'h123456);
    chk("ws_pending", swap_pending, 1);
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    tick();
    chk("ws_front", front, 1);
    chk("rd_addr_f1", rd_addr, 9'h165);

    // A second swap_req while pending is dropped
    swap_req = 1'b1;
    tick();
    tick();
    swap_req = 1'b0;
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    tick();
    chk("noq_front", front, 0);
    chk("noq_done", swap_done, 1);
    tick();
    chk("noq_pending", swap_pending, 0);
    chk("noq_ready", wr_ready, 1);
    disp_row = 3'd7; disp_column = 5'd31;
    #1;
    chk("rd_addr_max", rd_addr, 9'h0FF);

    // frame_count wraps 255 -> 0 (currently 5)
    frame_complete = 1'b1;
    repeat (251) tick();
    frame_complete = 1'b0;
    chk("fcount_wrap", frame_count, 0);
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    chk("fcount_after_wrap", frame_count, 1);

`ifdef DISPLAY_BUFFER_SCHEDULER_CLEAR_EN
    // Clear sweep of back bank 1, swap latched at cycle 10, frame end at 20
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) swap_req = 1'b1;
      if (i == 20) frame_complete = 1'b1;
      tick();
      swap_req = 1'b0; frame_complete = 1'b0;
      if (mem_we !== 1'b1 || mem_waddr !== 9'(256 + i) || mem_wdata !== 24'h0 || wr_ready !== 1'b0) bad++;
    end
    chk("clr_sweep", bad, 0);
    chk("clr_pending", swap_pending, 1);
    chk("clr_front_held", front, 0);
    chk("clr_fcount", frame_count, 2);
    tick();
    chk("clr_we_end", mem_we, 0);
    chk("clr_ready_low", wr_ready, 0);
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    tick();
    chk("clr_swap_front", front, 1);
    chk("clr_swap_done", swap_done, 1);
    // Start another clear and reset it mid-sweep
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
`else
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    tick();
    chk("pre_rst_front", front, 1);
    // Write in flight plus pending swap, then reset
    wr_req = 1'b1; wr_row = 3'd0; wr_column = 5'd0; swap_req = 1'b1;
    tick();
    wr_req = 1'b0; swap_req = 1'b0;
`endif
    chk("pre_rst_we", mem_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_we", mem_we, 0);
    chk("async_rst_front", front, 0);
    chk("async_rst_pending", swap_pending, 0);
    chk("async_rst_fcount", frame_count, 0);
    chk("async_rst_waddr", mem_waddr, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", wr_ready, 1);
    chk("post_rst_we", mem_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
